// File: rtl/id_ex_decode_stage.sv
// ID-stage decoder and ID/EX pipeline register.
// Decodes instr_d into EX controls; supports stall, flush and illegal bubbles.
module id_ex_decode_stage #(
  parameter logic [4:0]  LINK_REG = 5'd31,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_plus4_d,
  input  logic        valid_d,
  input  logic        stall,
  input  logic        flush,
  output logic [4:0]  alu_control_e,
  output logic [31:0] imm_e,
  output logic [31:0] shamt_e,
  output logic [1:0]  src_a_sel_e,
  output logic        src_b_sel_e,
  output logic [4:0]  rs_e,
  output logic [4:0]  rt_e,
  output logic [4:0]  write_reg_e,
  output logic        reg_write_e,
  output logic        mem_to_reg_e,
  output logic        mem_write_e,
  output logic        branch_e,
  output logic        jump_e,
  output logic [31:0] pc_plus4_e,
  output logic        valid_e,
  output logic        illegal_e
);

  localparam logic [4:0] A_ADD   = 5'd0;
  localparam logic [4:0] A_ADDU  = 5'd1;
  localparam logic [4:0] A_SUB   = 5'd2;
  localparam logic [4:0] A_SUBU  = 5'd3;
  localparam logic [4:0] A_AND   = 5'd4;
  localparam logic [4:0] A_NOR   = 5'd5;
  localparam logic [4:0] A_OR    = 5'd6;
  localparam logic [4:0] A_XOR   = 5'd7;
  localparam logic [4:0] A_SLL   = 5'd8;
  localparam logic [4:0] A_SLLV  = 5'd9;
  localparam logic [4:0] A_SRL   = 5'd10;
  localparam logic [4:0] A_SRLV  = 5'd11;
  localparam logic [4:0] A_SRA   = 5'd12;
  localparam logic [4:0] A_SRAV  = 5'd13;
  localparam logic [4:0] A_SLT   = 5'd14;
  localparam logic [4:0] A_JR    = 5'd15;
  localparam logic [4:0] A_ADDI  = 5'd16;
  localparam logic [4:0] A_ADDIU = 5'd17;
  localparam logic [4:0] A_ANDI  = 5'd18;
  localparam logic [4:0] A_ORI   = 5'd19;
  localparam logic [4:0] A_BEQ   = 5'd20;
  localparam logic [4:0] A_BNE   = 5'd21;
  localparam logic [4:0] A_LW    = 5'd22;
  localparam logic [4:0] A_SW    = 5'd23;
  localparam logic [4:0] A_J     = 5'd24;
  localparam logic [4:0] A_JAL   = 5'd25;
  localparam logic [4:0] A_XORI  = 5'd26;

  typedef struct packed {
    logic [4:0]  alu;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr;
    logic        rw;
    logic        m2r;
    logic        mw;
    logic        br;
    logic        jmp;
    logic [31:0] pc;
    logic        vld;
    logic        ill;
  } id_ex_t;

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, sh;
  logic [31:0] sext, zext, bofs, jtgt;
  logic        is_r, is_ari, is_logi;
  logic        is_mem, is_br, is_j;
  logic        legal;
  id_ex_t      dec, bubble;
  id_ex_t      ex_d, ex_q;

  assign op   = instr_d[31:26];
  assign rs   = instr_d[25:21];
  assign rt   = instr_d[20:16];
  assign rd   = instr_d[15:11];
  assign sh   = instr_d[10:6];
  assign fn   = instr_d[5:0];
  assign sext = {{16{instr_d[15]}}, instr_d[15:0]};
  assign zext = {16'd0, instr_d[15:0]};
  assign bofs = {sext[29:0], 2'b00};
  assign jtgt = {pc_plus4_d[31:28], instr_d[25:0], 2'b00};

  assign is_r    = (op == 6'h00);
  assign is_ari  = (op == 6'h08) || (op == 6'h09);
  assign is_logi = (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
  assign is_mem  = (op == 6'h23) || (op == 6'h2B);
  assign is_br   = (op == 6'h04) || (op == 6'h05);
  assign is_j    = (op == 6'h02) || (op == 6'h03);

  always_comb begin
    dec       = '0;
    legal     = 1'b1;
    dec.alu   = A_ADDU;
    dec.rs    = rs;
    dec.rt    = rt;
    dec.shamt = sh;
    dec.pc    = pc_plus4_d;
    dec.vld   = 1'b1;
    unique case (1'b1)
      is_r: begin
        dec.wr = rd;
        dec.rw = 1'b1;
        case (fn)
          6'h20: dec.alu = A_ADD;
          6'h21: dec.alu = A_ADDU;
          6'h22: dec.alu = A_SUB;
          6'h23: dec.alu = A_SUBU;
          6'h24: dec.alu = A_AND;
          6'h25: dec.alu = A_OR;
          6'h26: dec.alu = A_XOR;
          6'h27: dec.alu = A_NOR;
          6'h2A: dec.alu = A_SLT;
          6'h00: begin
            dec.alu   = A_SLL;
            dec.a_sel = 2'd1;
          end
          6'h02: begin
            dec.alu   = A_SRL;
            dec.a_sel = 2'd1;
          end
          6'h03: begin
            dec.alu   = A_SRA;
            dec.a_sel = 2'd1;
          end
          6'h04: dec.alu = A_SLLV;
          6'h06: dec.alu = A_SRLV;
          6'h07: dec.alu = A_SRAV;
          6'h08: begin
            dec.alu = A_JR;
            dec.jmp = 1'b1;
            dec.rw  = 1'b0;
            dec.wr  = 5'd0;
          end
          default: legal = 1'b0;
        endcase
      end
      is_ari: begin
        dec.alu   = op[0] ? A_ADDIU : A_ADDI;
        dec.imm   = sext;
        dec.b_sel = 1'b1;
        dec.wr    = rt;
        dec.rw    = 1'b1;
      end
      is_logi: begin
        dec.alu   = (op[1:0] == 2'b00) ? A_ANDI :
                    (op[1:0] == 2'b01) ? A_ORI : A_XORI;
        dec.imm   = zext;
        dec.b_sel = 1'b1;
        dec.wr    = rt;
        dec.rw    = 1'b1;
      end
      is_mem: begin
        dec.imm   = sext;
        dec.b_sel = 1'b1;
        dec.wr    = rt;
        if (op[3]) begin
          dec.alu = A_SW;
          dec.mw  = 1'b1;
        end else begin
          dec.alu = A_LW;
          dec.rw  = 1'b1;
          dec.m2r = 1'b1;
        end
      end
      is_br: begin
        dec.alu = op[0] ? A_BNE : A_BEQ;
        dec.imm = bofs;
        dec.br  = 1'b1;
        dec.wr  = rt;
      end
      is_j: begin
        dec.imm = jtgt;
        dec.jmp = 1'b1;
        dec.wr  = rt;
        dec.alu = A_J;
        // JAL links through the ALU: A=pc+4, B forced to 0 in EX
        if (op[0]) begin
          dec.alu   = A_JAL;
          dec.a_sel = 2'd2;
          dec.b_sel = 1'b1;
          dec.wr    = LINK_REG;
          dec.rw    = 1'b1;
        end
      end
      default: legal = 1'b0;
    endcase
    dec.rw = dec.rw & (dec.wr != 5'd0);
  end

  always_comb begin
    bubble     = '0;
    bubble.alu = A_ADDU;
    ex_d       = ex_q;
    if (flush) begin
      ex_d = bubble;
    end else if (!stall) begin
      if (!valid_d) begin
        ex_d = bubble;
      end else if (!legal) begin
        ex_d     = bubble;
        ex_d.ill = 1'b1;
      end else begin
        ex_d = dec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      ex_q.pc <= RESET_PC;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign alu_control_e = ex_q.alu;
  assign imm_e         = ex_q.imm;
  assign shamt_e       = {27'd0, ex_q.shamt};
  assign src_a_sel_e   = ex_q.a_sel;
  assign src_b_sel_e   = ex_q.b_sel;
  assign rs_e          = ex_q.rs;
  assign rt_e          = ex_q.rt;
  assign write_reg_e   = ex_q.wr;
  assign reg_write_e   = ex_q.rw;
  assign mem_to_reg_e  = ex_q.m2r;
  assign mem_write_e   = ex_q.mw;
  assign branch_e      = ex_q.br;
  assign jump_e        = ex_q.jmp;
  assign pc_plus4_e    = ex_q.pc;
  assign valid_e       = ex_q.vld;
  assign illegal_e     = ex_q.ill;

endmodule

// File: tb/tb_id_ex_decode_stage.sv
// Bench for id_ex_decode_stage: directed table, corner sequences,
// and random traffic against a mnemonic-level reference model.
module tb_id_ex_decode_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_d, pc_plus4_d;
  logic        valid_d, stall, flush;
  logic [4:0]  alu_control_e;
  logic [31:0] imm_e, shamt_e;
  logic [1:0]  src_a_sel_e;
  logic        src_b_sel_e;
  logic [4:0]  rs_e, rt_e, write_reg_e;
  logic        reg_write_e, mem_to_reg_e, mem_write_e;
  logic        branch_e, jump_e;
  logic [31:0] pc_plus4_e;
  logic        valid_e, illegal_e;

  id_ex_decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .instr_d(instr_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .stall(stall), .flush(flush),
    .alu_control_e(alu_control_e), .imm_e(imm_e),
    .shamt_e(shamt_e), .src_a_sel_e(src_a_sel_e),
    .src_b_sel_e(src_b_sel_e), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .reg_write_e(reg_write_e),
    .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
    .branch_e(branch_e), .jump_e(jump_e),
    .pc_plus4_e(pc_plus4_e), .valid_e(valid_e),
    .illegal_e(illegal_e)
  );

  typedef struct packed {
    logic [4:0]  alu;
    logic [31:0] imm;
    logic [31:0] shamt;
    logic [1:0]  asel;
    logic        bsel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr;
    logic        rw;
    logic        m2r;
    logic        mw;
    logic        br;
    logic        jmp;
    logic [31:0] pc;
    logic        vld;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        v, s, f;
    logic [4:0]  alu;
    logic [31:0] imm;
    logic [4:0]  wr;
    logic        rw, vld, ill;
  } vec_t;

  exp_t act, exp_s;
  int   r_alu[int];
  int   i_alu[int];
  int   total = 0;
  int   passed = 0;
  vec_t vecs[$];

  assign act = {alu_control_e, imm_e, shamt_e, src_a_sel_e,
                src_b_sel_e, rs_e, rt_e, write_reg_e, reg_write_e,
                mem_to_reg_e, mem_write_e, branch_e, jump_e,
                pc_plus4_e, valid_e, illegal_e};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t bub();
    exp_t e;
    e = '0;
    e.alu = 5'd1;
    return e;
  endfunction

  // Reference decode: mnemonic code from lookup tables, then
  // per-instruction properties from the instruction-set rules.
  function automatic exp_t ref_dec(input logic [31:0] i,
                                   input logic [31:0] pc);
    exp_t e;
    int op, fn, c, s16;
    e   = bub();
    op  = int'(i[31:26]);
    fn  = int'(i[5:0]);
    c   = -1;
    s16 = int'($signed(i[15:0]));
    if (op == 0) begin
      if (r_alu.exists(fn)) c = r_alu[fn];
    end else if (i_alu.exists(op)) begin
      c = i_alu[op];
    end
    if (c < 0) begin
      e.ill = 1'b1;
      return e;
    end
    e.alu   = 5'(c);
    e.vld   = 1'b1;
    e.rs    = i[25:21];
    e.rt    = i[20:16];
    e.shamt = 32'(i[10:6]);
    e.pc    = pc;
    if (c inside {16, 17, 22, 23}) e.imm = 32'(s16);
    if (c inside {18, 19, 26})     e.imm = 32'(i[15:0]);
    if (c inside {20, 21})         e.imm = 32'(s16 * 4);
    if (c inside {24, 25})
      e.imm = (pc & 32'hF000_0000) | (32'(i[25:0]) * 32'd4);
    if (c inside {8, 10, 12}) e.asel = 2'd1;
    if (c == 25)              e.asel = 2'd2;
    e.bsel = (c inside {16, 17, 18, 19, 22, 23, 25, 26});
    if (op == 0)      e.wr = (c == 15) ? 5'd0 : i[15:11];
    else if (c == 25) e.wr = 5'd31;
    else              e.wr = i[20:16];
    e.rw  = !(c inside {15, 20, 21, 23, 24}) && (e.wr != 5'd0);
    e.m2r = (c == 22);
    e.mw  = (c == 23);
    e.br  = (c inside {20, 21});
    e.jmp = (c inside {15, 24, 25});
    return e;
  endfunction

  task automatic check(input string nm, input exp_t a, input exp_t e);
    total++;
    if (a !== e)
      $display("FAIL %s: got %h want %h", nm, a, e);
    else
      passed++;
  endtask

  task automatic step(input logic [31:0] i, input logic [31:0] pc,
                      input logic v, input logic s, input logic f);
    exp_t nxt;
    instr_d = i;
    pc_plus4_d = pc;
    valid_d = v;
    stall = s;
    flush = f;
    if (f)       nxt = bub();
    else if (s)  nxt = exp_s;
    else if (!v) nxt = bub();
    else         nxt = ref_dec(i, pc);
    @(posedge clk);
    #1;
    exp_s = nxt;
    check("model", act, exp_s);
  endtask

  initial begin
    int rfn[16] = '{32, 33, 34, 35, 36, 37, 38, 39, 42,
                    0, 2, 3, 4, 6, 7, 8};
    int iop[10] = '{8, 9, 12, 13, 14, 35, 43, 4, 5, 2};
    logic [44:0] kg, kw;
    logic [31:0] ri;

    r_alu[32] = 0;  r_alu[33] = 1;  r_alu[34] = 2;  r_alu[35] = 3;
    r_alu[36] = 4;  r_alu[37] = 6;  r_alu[38] = 7;  r_alu[39] = 5;
    r_alu[42] = 14; r_alu[0] = 8;   r_alu[2] = 10;  r_alu[3] = 12;
    r_alu[4] = 9;   r_alu[6] = 11;  r_alu[7] = 13;  r_alu[8] = 15;
    i_alu[8] = 16;  i_alu[9] = 17;  i_alu[12] = 18; i_alu[13] = 19;
    i_alu[14] = 26; i_alu[35] = 22; i_alu[43] = 23; i_alu[4] = 20;
    i_alu[5] = 21;  i_alu[2] = 24;  i_alu[3] = 25;

    vecs.push_back('{32'h012A4020, 32'h4, 1, 0, 0, 5'd0, 32'h0, 5'd8, 1, 1, 0});
    vecs.push_back('{32'h2108FFFF, 32'h8, 1, 0, 0, 5'd16, 32'hFFFFFFFF, 5'd8, 1, 1, 0});
    vecs.push_back('{32'h3508FFFF, 32'hC, 1, 0, 0, 5'd19, 32'h0000FFFF, 5'd8, 1, 1, 0});
    vecs.push_back('{32'h00031103, 32'h10, 1, 0, 0, 5'd12, 32'h0, 5'd2, 1, 1, 0});
    vecs.push_back('{32'h00000000, 32'h14, 1, 0, 0, 5'd8, 32'h0, 5'd0, 0, 1, 0});
    vecs.push_back('{32'h8D090004, 32'h18, 1, 0, 0, 5'd22, 32'h4, 5'd9, 1, 1, 0});
    vecs.push_back('{32'h012A4020, 32'h1C, 1, 1, 0, 5'd22, 32'h4, 5'd9, 1, 1, 0});
    vecs.push_back('{32'h2108FFFF, 32'h20, 1, 1, 0, 5'd22, 32'h4, 5'd9, 1, 1, 0});
    vecs.push_back('{32'hFC000000, 32'h24, 1, 1, 0, 5'd22, 32'h4, 5'd9, 1, 1, 0});
    vecs.push_back('{32'h012A4020, 32'h28, 1, 1, 1, 5'd1, 32'h0, 5'd0, 0, 0, 0});
    vecs.push_back('{32'h1109FFFF, 32'h2C, 1, 0, 0, 5'd20, 32'hFFFFFFFC, 5'd9, 0, 1, 0});
    vecs.push_back('{32'h0C000010, 32'h00400004, 1, 0, 0, 5'd25, 32'h40, 5'd31, 1, 1, 0});
    vecs.push_back('{32'hFC000000, 32'h30, 1, 0, 0, 5'd1, 32'h0, 5'd0, 0, 0, 1});
    vecs.push_back('{32'h012A4020, 32'h34, 1, 0, 0, 5'd0, 32'h0, 5'd8, 1, 1, 0});
    vecs.push_back('{32'h012A4020, 32'h38, 0, 0, 0, 5'd1, 32'h0, 5'd0, 0, 0, 0});
    vecs.push_back('{32'hAD090008, 32'h3C, 1, 0, 0, 5'd23, 32'h8, 5'd9, 0, 1, 0});
    vecs.push_back('{32'h08000100, 32'h10000004, 1, 0, 0, 5'd24, 32'h10000400, 5'd0, 0, 1, 0});
    vecs.push_back('{32'h03E00008, 32'h40, 1, 0, 0, 5'd15, 32'h0, 5'd0, 0, 1, 0});
    vecs.push_back('{32'h012A0020, 32'h44, 1, 0, 0, 5'd0, 32'h0, 5'd0, 0, 1, 0});

    rst_n = 1'b0;
    instr_d = '0;
    pc_plus4_d = '0;
    valid_d = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    #3;
    exp_s = '0;
    check("reset", act, exp_s);
    #9;
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      step(vecs[k].instr, vecs[k].pc, vecs[k].v, vecs[k].s, vecs[k].f);
      kg = {alu_control_e, imm_e, write_reg_e, reg_write_e,
            valid_e, illegal_e};
      kw = {vecs[k].alu, vecs[k].imm, vecs[k].wr, vecs[k].rw,
            vecs[k].vld, vecs[k].ill};
      total++;
      if (kg !== kw)
        $display("FAIL vec%0d: got %h want %h", k, kg, kw);
      else
        passed++;
    end

    // Asynchronous reset landing mid-cycle with a live instruction
    step(32'h8D090004, 32'h50, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_s = '0;
    check("async_rst", act, exp_s);
    @(negedge clk);
    rst_n = 1'b1;
    step(32'h012A4020, 32'h54, 1, 0, 0);

    // Stall holds an illegal bubble; next legal load clears it
    step(32'hFC00FFFF, 32'h58, 1, 0, 0);
    step(32'h012A4020, 32'h5C, 1, 1, 0);
    step(32'h012A4020, 32'h60, 1, 0, 0);

    for (int n = 0; n < 400; n++) begin
      ri = $urandom;
      case ($urandom_range(0, 7))
        0, 1, 2: begin
          ri[31:26] = 6'd0;
          ri[5:0] = 6'(rfn[$urandom_range(0, 15)]);
        end
        3, 4, 5: ri[31:26] = 6'(iop[$urandom_range(0, 9)]);
        6: ri[31:26] = 6'd3;
        default: ;
      endcase
      step(ri, $urandom, $urandom_range(0, 7) != 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
